// File: rtl/ocs_perm_stim_checker.sv
// Self-checking stimulus engine for the NxN optical circuit switch controller.
// Builds conflict-free permutations, issues them as requests, waits for the
// controller grant, drives the fabric model and checks output j carries j.
module ocs_perm_stim_checker #(
  parameter int          P_PORTNUM    = 8,
  parameter int          P_DSTWIDTH   = 3,
  parameter int          P_GRANTWIDTH = 20,
  parameter int          P_CNTWIDTH   = 16,
  parameter int          P_TIMEOUT    = 1023,
  parameter logic [31:0] P_SEED       = 32'hACE12D5B
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_start,
  input  logic [P_CNTWIDTH-1:0]             i_test_num,
  input  logic [1:0]                        i_mode,
  output logic [P_PORTNUM*P_DSTWIDTH-1:0]   o_req,
  output logic                              o_req_valid,
  input  logic [P_GRANTWIDTH-1:0]           i_grant,
  input  logic                              i_grant_valid,
  output logic [P_GRANTWIDTH-1:0]           o_grant,
  output logic [P_PORTNUM*P_DSTWIDTH-1:0]   o_chk_data,
  input  logic [P_PORTNUM*P_DSTWIDTH-1:0]   i_fabric_data,
  output logic                              o_busy,
  output logic                              o_done,
  output logic [P_CNTWIDTH-1:0]             o_test_cnt,
  output logic [P_CNTWIDTH-1:0]             o_err_cnt,
  output logic [P_CNTWIDTH-1:0]             o_timeout_cnt
);

  localparam int N  = P_PORTNUM;
  localparam int W  = P_DSTWIDTH;
  localparam int C  = P_CNTWIDTH;
  localparam int TW = (P_TIMEOUT > 1) ? $clog2(P_TIMEOUT) : 1;

  // Galois form of x^32 + x^22 + x^2 + x + 1, shifting right.
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  localparam logic [1:0] MODE_ID  = 2'd1;
  localparam logic [1:0] MODE_ROT = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_SHUFFLE, S_ISSUE, S_WAIT_GRANT, S_CHECK, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [W-1:0]      perm_q [N];
  logic [W-1:0]      perm_d [N];
  logic [31:0]       lfsr_q;
  logic [W-1:0]      k_q, k_d;
  logic [TW-1:0]     wait_q, wait_d;
  logic [C-1:0]      test_num_q, test_num_d;
  logic [1:0]        mode_q, mode_d;
  logic [N*W-1:0]    req_q, req_d;
  logic              req_valid_q, req_valid_d;
  logic [P_GRANTWIDTH-1:0] grant_q, grant_d;
  logic [N*W-1:0]    chk_q, chk_d;
  logic [C-1:0]      test_cnt_q, test_cnt_d;
  logic [C-1:0]      err_cnt_q, err_cnt_d;
  logic [C-1:0]      to_cnt_q, to_cnt_d;

  logic [N*W-1:0]    perm_pack;
  logic [N-1:0]      field_ok;
  logic [W-1:0]      swap_j;
  logic              last_test;

  // Packed view of the permutation after this cycle's shuffle step, and the
  // per-port "output j carries j" flags of the fabric response.
  for (genvar gi = 0; gi < N; gi++) begin : g_fields
    assign perm_pack[gi*W +: W] = perm_d[gi];
    assign field_ok[gi]         = (i_fabric_data[gi*W +: W] == W'(gi));
  end

  assign last_test = ((test_cnt_q + C'(1)) == test_num_q);

  // Permutation update: one Fisher-Yates swap (random), one-shot rotation, or hold.
  always_comb begin
    for (int i = 0; i < N; i++) perm_d[i] = perm_q[i];
    swap_j = W'(lfsr_q[15:0] % (16'(k_q) + 16'd1));
    if (state_q == S_SHUFFLE) begin
      if (mode_q == MODE_ROT) begin
        if (k_q == W'(N - 1)) begin
          for (int i = 0; i < N; i++) perm_d[i] = W'((i + int'(test_cnt_q % C'(N))) % N);
        end
      end else if (mode_q != MODE_ID) begin
        perm_d[k_q]    = perm_q[swap_j];
        perm_d[swap_j] = perm_q[k_q];
      end
    end
  end

  // Next-state and datapath decisions for the run sequencer.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    wait_d      = wait_q;
    test_num_d  = test_num_q;
    mode_d      = mode_q;
    req_d       = req_q;
    req_valid_d = 1'b0;
    grant_d     = grant_q;
    chk_d       = chk_q;
    test_cnt_d  = test_cnt_q;
    err_cnt_d   = err_cnt_q;
    to_cnt_d    = to_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          test_num_d = i_test_num;
          mode_d     = i_mode;
          test_cnt_d = '0;
          err_cnt_d  = '0;
          to_cnt_d   = '0;
          k_d        = W'(N - 1);
          state_d    = (i_test_num == '0) ? S_DONE : S_SHUFFLE;
        end
      end
      S_SHUFFLE: begin
        if (k_q == W'(1)) begin
          // Load the request on the final step so it is valid during ISSUE.
          req_d       = perm_pack;
          req_valid_d = 1'b1;
          state_d     = S_ISSUE;
        end else begin
          k_d = k_q - W'(1);
        end
      end
      S_ISSUE: begin
        wait_d  = '0;
        state_d = S_WAIT_GRANT;
      end
      S_WAIT_GRANT: begin
        if (i_grant_valid) begin
          grant_d = i_grant;
          chk_d   = req_q;
          state_d = S_CHECK;
        end else if (wait_q == TW'(P_TIMEOUT - 1)) begin
          test_cnt_d = test_cnt_q + C'(1);
          err_cnt_d  = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + C'(1);
          to_cnt_d   = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + C'(1);
          k_d        = W'(N - 1);
          state_d    = last_test ? S_DONE : S_SHUFFLE;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end
      S_CHECK: begin
        test_cnt_d = test_cnt_q + C'(1);
        if (!(&field_ok)) begin
          err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + C'(1);
        end
        k_d     = W'(N - 1);
        state_d = last_test ? S_DONE : S_SHUFFLE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, permutation, LFSR and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < N; i++) perm_q[i] <= W'(i);
      lfsr_q      <= P_SEED;
      k_q         <= '0;
      wait_q      <= '0;
      test_num_q  <= '0;
      mode_q      <= '0;
      req_q       <= '0;
      req_valid_q <= 1'b0;
      grant_q     <= '0;
      chk_q       <= '0;
      test_cnt_q  <= '0;
      err_cnt_q   <= '0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      for (int i = 0; i < N; i++) perm_q[i] <= perm_d[i];
      lfsr_q      <= {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_MASK : 32'd0);
      k_q         <= k_d;
      wait_q      <= wait_d;
      test_num_q  <= test_num_d;
      mode_q      <= mode_d;
      req_q       <= req_d;
      req_valid_q <= req_valid_d;
      grant_q     <= grant_d;
      chk_q       <= chk_d;
      test_cnt_q  <= test_cnt_d;
      err_cnt_q   <= err_cnt_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign o_req         = req_q;
  assign o_req_valid   = req_valid_q;
  assign o_grant       = grant_q;
  assign o_chk_data    = chk_q;
  assign o_busy        = (state_q != S_IDLE);
  assign o_done        = (state_q == S_DONE);
  assign o_test_cnt    = test_cnt_q;
  assign o_err_cnt     = err_cnt_q;
  assign o_timeout_cnt = to_cnt_q;

endmodule
